// File: rtl/audio_bit_serializer.sv
// I2S / left-justified transmit serializer: one-entry sample-pair buffer feeding
// an MSB-first shifter paced by pre-detected bit-clock and LR-clock strobes.
module audio_bit_serializer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned MODE       = 0,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bit_clk_rising_edge,
    input  logic                  bit_clk_falling_edge,
    input  logic                  left_right_clk_rising_edge,
    input  logic                  left_right_clk_falling_edge,
    input  logic [DATA_WIDTH-1:0] left_data,
    input  logic [DATA_WIDTH-1:0] right_data,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  serial_data,
    output logic                  counting,
    output logic                  channel,
    output logic                  underflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    // I2S waits one bit clock after the LR edge; left-justified starts shifting at once
    localparam logic [1:0] ST_SLOT  = (MODE == 0) ? ST_DELAY : ST_SHIFT;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1);

    logic [1:0]            state_q,      state_next;
    logic [DATA_WIDTH-1:0] shift_q,      shift_next;
    logic [CNT_WIDTH-1:0]  cnt_q,        cnt_next;
    logic [DATA_WIDTH-1:0] act_left_q,   act_left_next;
    logic [DATA_WIDTH-1:0] act_right_q,  act_right_next;
    logic [DATA_WIDTH-1:0] buf_left_q,   buf_left_next;
    logic [DATA_WIDTH-1:0] buf_right_q,  buf_right_next;
    logic                  ready_next;
    logic                  serial_next;
    logic                  counting_next;
    logic                  channel_next;
    logic                  underflow_next;
    logic                  accept;
    logic                  left_start;
    logic                  right_start;
    logic                  unused_bclk_rise;

    assign unused_bclk_rise = bit_clk_rising_edge;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            act_left_q  <= '0;
            act_right_q <= '0;
            buf_left_q  <= '0;
            buf_right_q <= '0;
            data_ready  <= 1'b1;
            serial_data <= 1'b0;
            counting    <= 1'b0;
            channel     <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state_q     <= state_next;
            shift_q     <= shift_next;
            cnt_q       <= cnt_next;
            act_left_q  <= act_left_next;
            act_right_q <= act_right_next;
            buf_left_q  <= buf_left_next;
            buf_right_q <= buf_right_next;
            data_ready  <= ready_next;
            serial_data <= serial_next;
            counting    <= counting_next;
            channel     <= channel_next;
            underflow   <= underflow_next;
        end
    end

    // Next-state: slot loading, bit shifting and buffer handshake
    always_comb begin
        state_next     = state_q;
        shift_next     = shift_q;
        cnt_next       = cnt_q;
        act_left_next  = act_left_q;
        act_right_next = act_right_q;
        buf_left_next  = buf_left_q;
        buf_right_next = buf_right_q;
        ready_next     = data_ready;
        channel_next   = channel;
        underflow_next = 1'b0;

        accept      = data_valid & data_ready;
        right_start = left_right_clk_rising_edge;
        left_start  = left_right_clk_falling_edge & ~left_right_clk_rising_edge;

        if (right_start) begin
            channel_next = 1'b1;
            shift_next   = act_right_q;
            cnt_next     = CNT_LOAD;
            state_next   = ST_SLOT;
        end else if (left_start) begin
            channel_next = 1'b0;
            cnt_next     = CNT_LOAD;
            state_next   = ST_SLOT;
            if (!data_ready) begin
                act_left_next  = buf_left_q;
                act_right_next = buf_right_q;
                shift_next     = buf_left_q;
            end else begin
                // Empty buffer: play silence for this frame
                act_left_next  = '0;
                act_right_next = '0;
                shift_next     = '0;
                underflow_next = 1'b1;
            end
        end else if (bit_clk_falling_edge) begin
            case (state_q)
                ST_DELAY: state_next = ST_SHIFT;
                ST_SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        shift_next = shift_q << 1;
                        cnt_next   = cnt_q - CNT_LAST;
                    end
                end
                default: state_next = state_q;
            endcase
        end

        // Accept only when empty, so a left start never coincides with a full-buffer accept
        if (accept) begin
            buf_left_next  = left_data;
            buf_right_next = right_data;
            ready_next     = 1'b0;
        end else if (left_start) begin
            ready_next = 1'b1;
        end

        serial_next   = (state_next == ST_SHIFT) ? shift_next[DATA_WIDTH-1] : 1'b0;
        counting_next = (state_next != ST_IDLE);
    end

endmodule

// File: tb/tb_audio_bit_serializer.sv
// Bench for audio_bit_serializer: I2S and left-justified instances driven in
// parallel, compared each cycle against a bit-index model of the audio frame.
module tb_audio_bit_serializer;

    localparam int unsigned DW = 24;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          bcr, bcf, lrr, lrf, dv;
    logic [DW-1:0] ld, rd;
    logic          rdy0, sd0, cnt0, ch0, uf0;
    logic          rdy1, sd1, cnt1, ch1, uf1;

    always #5 clk = ~clk;

    audio_bit_serializer #(.DATA_WIDTH(DW), .MODE(0), .CNT_WIDTH(6)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .bit_clk_rising_edge(bcr), .bit_clk_falling_edge(bcf),
        .left_right_clk_rising_edge(lrr), .left_right_clk_falling_edge(lrf),
        .left_data(ld), .right_data(rd), .data_valid(dv), .data_ready(rdy0),
        .serial_data(sd0), .counting(cnt0), .channel(ch0), .underflow(uf0)
    );

    audio_bit_serializer #(.DATA_WIDTH(DW), .MODE(1), .CNT_WIDTH(6)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .bit_clk_rising_edge(bcr), .bit_clk_falling_edge(bcf),
        .left_right_clk_rising_edge(lrr), .left_right_clk_falling_edge(lrf),
        .left_data(ld), .right_data(rd), .data_valid(dv), .data_ready(rdy1),
        .serial_data(sd1), .counting(cnt1), .channel(ch1), .underflow(uf1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: slot word plus number of bit-clock falls since slot start
    logic          m_buf_valid, m_in_slot, m_chan, m_uf;
    logic [DW-1:0] m_buf_l, m_buf_r, m_act_l, m_act_r, m_word;
    int            m_falls;
    logic [2*DW-1:0] pend[$];

    task automatic model_reset();
        m_buf_valid = 1'b0; m_in_slot = 1'b0; m_chan = 1'b0; m_uf = 1'b0;
        m_buf_l = '0; m_buf_r = '0; m_act_l = '0; m_act_r = '0; m_word = '0;
        m_falls = 0;
    endtask

    function automatic logic exp_sd(int md);
        int pos;
        pos = m_falls - ((md == 0) ? 1 : 0);
        if (!m_in_slot || pos < 0 || pos >= int'(DW)) return 1'b0;
        return m_word[DW-1-pos];
    endfunction

    function automatic logic exp_cnt(int md);
        return m_in_slot && (m_falls < int'(DW) + ((md == 0) ? 1 : 0));
    endfunction

    task automatic chk(string tag, logic obs, logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    endtask

    task automatic check_outputs();
        chk("ready_i2s", rdy0, !m_buf_valid);
        chk("ready_lj",  rdy1, !m_buf_valid);
        chk("underflow_i2s", uf0, m_uf);
        chk("underflow_lj",  uf1, m_uf);
        chk("channel_i2s", ch0, m_chan);
        chk("channel_lj",  ch1, m_chan);
        chk("counting_i2s", cnt0, exp_cnt(0));
        chk("counting_lj",  cnt1, exp_cnt(1));
        chk("serial_i2s", sd0, exp_sd(0));
        chk("serial_lj",  sd1, exp_sd(1));
    endtask

    task automatic drive_data();
        dv = (pend.size() > 0);
        if (dv) {ld, rd} = pend[0];
    endtask

    task automatic offer(logic [DW-1:0] l, logic [DW-1:0] r);
        pend.push_back({l, r});
        drive_data();
    endtask

    // One clock: DUT samples inputs at the edge, model follows, outputs checked
    task automatic cycle();
        logic acc, left, right;
        @(posedge clk);
        acc   = dv && !m_buf_valid;
        right = lrr;
        left  = lrf && !lrr;
        m_uf  = 1'b0;
        if (left) begin
            if (m_buf_valid) begin
                m_act_l = m_buf_l; m_act_r = m_buf_r; m_buf_valid = 1'b0;
            end else begin
                m_act_l = '0; m_act_r = '0; m_uf = 1'b1;
            end
            m_chan = 1'b0; m_word = m_act_l; m_falls = 0; m_in_slot = 1'b1;
        end else if (right) begin
            m_chan = 1'b1; m_word = m_act_r; m_falls = 0; m_in_slot = 1'b1;
        end else if (bcf && m_falls < 100) begin
            m_falls++;
        end
        if (acc) begin
            {m_buf_l, m_buf_r} = {ld, rd};
            m_buf_valid = 1'b1;
            void'(pend.pop_front());
        end
        #1;
        check_outputs();
        bcr = 1'b0; bcf = 1'b0; lrr = 1'b0; lrf = 1'b0;
        drive_data();
    endtask

    task automatic bits(int n, int gap);
        repeat (n) begin
            bcf = 1'b1;
            cycle();
            repeat (gap) cycle();
            bcr = 1'b1;
            cycle();
            repeat (gap) cycle();
        end
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        pend.delete();
        bcr = 1'b0; bcf = 1'b0; lrr = 1'b0; lrf = 1'b0; dv = 1'b0;
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        bcr = 1'b0; bcf = 1'b0; lrr = 1'b0; lrf = 1'b0; dv = 1'b0;
        ld = '0; rd = '0;
        model_reset();
        do_reset();
        repeat (3) cycle();

        // Underflow: no pair before the left slot, both slots silent
        lrf = 1'b1; cycle();
        bits(30, 1);
        lrr = 1'b1; cycle();
        bits(30, 1);

        // Known pattern, full frame in both framing modes
        offer(24'hA5A5A5, 24'h3C3C3C);
        cycle(); cycle();
        lrf = 1'b1; cycle();
        bits(32, 1);
        lrr = 1'b1; cycle();
        bits(32, 1);

        // Two pairs offered back to back mid-frame: second stalls until next left start
        lrf = 1'b1; cycle();
        offer(24'h123456, 24'hFEDCBA);
        offer(24'h800001, 24'h7FFFFE);
        bits(28, 1);
        lrr = 1'b1; cycle();
        bits(28, 1);
        lrf = 1'b1; cycle();
        bits(12, 1);

        // LR falling with a coincident bit fall, then early LR rising truncates
        lrf = 1'b1; bcf = 1'b1; cycle();
        bits(10, 1);
        lrr = 1'b1; cycle();
        bits(30, 1);

        // Randomised frames: random data, gaps, truncation and coincident strobes
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) != 0) offer(DW'($urandom), DW'($urandom));
            lrf = 1'b1;
            if ($urandom_range(0, 3) == 0) bcf = 1'b1;
            cycle();
            bits(int'($urandom_range(8, 30)), int'($urandom_range(0, 2)));
            lrr = 1'b1;
            if ($urandom_range(0, 3) == 0) lrf = 1'b1;
            if ($urandom_range(0, 3) == 0) bcf = 1'b1;
            cycle();
            bits(int'($urandom_range(8, 30)), int'($urandom_range(0, 2)));
        end

        // Async reset mid-shift with a pair still buffered
        offer(24'hC0FFEE, 24'h0BEEF0);
        cycle(); cycle();
        lrf = 1'b1; cycle();
        offer(24'h111111, 24'h222222);
        bits(6, 1);
        do_reset();
        repeat (2) cycle();
        lrf = 1'b1; cycle();
        bits(26, 1);
        lrr = 1'b1; cycle();
        bits(26, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
